// File: rtl/pipelined_add_sub.sv
// pipelined_add_sub: N-bit add/subtract split into STAGES slices of W = N/STAGES
// bits. Stage k adds slice k and registers its carry into stage k+1. Operand
// slices that are not yet processed ride along (skew), and finished result
// slices accumulate as the transaction moves (deskew). Because of this, the
// last stage register holds the whole aligned result. The whole pipe advances
// as one unit when the output slot is empty or is being consumed.
// Optional feature: define PIPELINED_ADD_SUB_OVERFLOW_EN to produce a registered
// two's-complement overflow flag. Without it, overflow is tied to 0.
module pipelined_add_sub #(
    parameter int N      = 32,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         carry_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] c,
    output logic         carry_out,
    output logic         overflow
);
    localparam int W = N / STAGES;

    logic adv_s;

    // One slice of the adder. Subtract inverts B here; the +1 arrives as the
    // carry into slice 0.
    function automatic logic [W:0] slice_add(
        input logic [W-1:0] a_s,
        input logic [W-1:0] b_s,
        input logic         sub_s,
        input logic         cin_s
    );
        logic [W-1:0] b_eff;
        b_eff = b_s ^ {W{sub_s}};
        return {1'b0, a_s} + {1'b0, b_eff} + {{W{1'b0}}, cin_s};
    endfunction

    // The pipe moves only when the output register is free or is being drained.
    assign adv_s    = !out_valid || out_ready;
    assign in_ready = adv_s && !rst;

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            localparam int RW = (k + 1) * W;   // result bits finished after this stage

            logic          vld_s;
            logic          op_s;
            logic          cin_s;
            logic [W-1:0]  a_sl_s;
            logic [W-1:0]  b_sl_s;
            logic [W:0]    sum_s;
            logic [RW-1:0] r_d;
            logic          vld_q;
            logic          cy_q;
            logic [RW-1:0] r_q;

            if (k == 0) begin : g_src
                assign vld_s  = in_valid;
                assign op_s   = op;
                assign cin_s  = op ? 1'b1 : carry_in;
                assign a_sl_s = a[W-1:0];
                assign b_sl_s = b[W-1:0];
                assign r_d    = sum_s[W-1:0];
            end else begin : g_src
                assign vld_s  = g_stage[k-1].vld_q;
                assign op_s   = g_stage[k-1].g_fwd.op_q;
                assign cin_s  = g_stage[k-1].cy_q;
                assign a_sl_s = g_stage[k-1].g_fwd.a_q[W-1:0];
                assign b_sl_s = g_stage[k-1].g_fwd.b_q[W-1:0];
                assign r_d    = {sum_s[W-1:0], g_stage[k-1].r_q};
            end

            assign sum_s = slice_add(a_sl_s, b_sl_s, op_s, cin_s);

            // Stage k register: valid bit, slice carry-out and finished result slices.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_q <= 1'b0;
                    cy_q  <= 1'b0;
                    r_q   <= {RW{1'b0}};
                end else if (adv_s) begin
                    vld_q <= vld_s;
                    cy_q  <= sum_s[W];
                    r_q   <= r_d;
                end
            end

            if (k < STAGES - 1) begin : g_fwd
                localparam int OW = N - RW;    // operand bits still waiting for a stage

                logic          op_q;
                logic [OW-1:0] a_q;
                logic [OW-1:0] b_q;
                logic [OW-1:0] a_rest_s;
                logic [OW-1:0] b_rest_s;

                if (k == 0) begin : g_rest
                    assign a_rest_s = a[N-1:W];
                    assign b_rest_s = b[N-1:W];
                end else begin : g_rest
                    assign a_rest_s = g_stage[k-1].g_fwd.a_q[N-k*W-1:W];
                    assign b_rest_s = g_stage[k-1].g_fwd.b_q[N-k*W-1:W];
                end

                // Skew the unprocessed operand slices and the op bit one stage forward.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        op_q <= 1'b0;
                        a_q  <= {OW{1'b0}};
                        b_q  <= {OW{1'b0}};
                    end else if (adv_s) begin
                        op_q <= op_s;
                        a_q  <= a_rest_s;
                        b_q  <= b_rest_s;
                    end
                end
            end
        end
    endgenerate

    assign out_valid = g_stage[STAGES-1].vld_q;
    assign c         = g_stage[STAGES-1].r_q;
    assign carry_out = g_stage[STAGES-1].cy_q;

`ifdef PIPELINED_ADD_SUB_OVERFLOW_EN
    // The carry into the MSB is recovered as a ^ b_eff ^ sum at that bit.
    function automatic logic ovf_flag(
        input logic a_msb,
        input logic b_eff_msb,
        input logic sum_msb,
        input logic cout
    );
        return (a_msb ^ b_eff_msb ^ sum_msb) ^ cout;
    endfunction

    logic ovf_d;
    logic ovf_q;

    assign ovf_d = ovf_flag(g_stage[STAGES-1].a_sl_s[W-1],
                            g_stage[STAGES-1].b_sl_s[W-1] ^ g_stage[STAGES-1].op_s,
                            g_stage[STAGES-1].sum_s[W-1],
                            g_stage[STAGES-1].sum_s[W]);

    // Overflow is registered with the final result slice so that it stays aligned with c.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (adv_s) begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Bench for pipelined_add_sub. It instantiates four configurations
// (32/4, 8/2, 16/4, 8/1) and checks each against a plain-arithmetic model
// through per-instance scoreboards, plus literal expectations.
module tb_pipelined_add_sub;

`ifdef PIPELINED_ADD_SUB_OVERFLOW_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    typedef struct packed {
        logic        ov;
        logic        co;
        logic [31:0] c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid_t  [4];
    logic        in_ready_t  [4];
    logic        op_t        [4];
    logic        cin_t       [4];
    logic        out_valid_t [4];
    logic        out_ready_t [4];
    logic        co_t        [4];
    logic        ov_t        [4];
    logic [31:0] a_t         [4];
    logic [31:0] b_t         [4];
    logic [31:0] c_t         [4];
    logic [31:0] c0;
    logic [7:0]  c1;
    logic [15:0] c2;
    logic [7:0]  c3;

    int   nw [4] = '{32, 8, 16, 8};
    exp_t sb_q [4][$];
    int   delivered [4] = '{0, 0, 0, 0};
    int   checks = 0;
    int   errors = 0;

    logic [31:0] va [8];
    logic [31:0] vb [8];
    logic        vop [8];
    logic        vcin [8];

    always #5 clk = ~clk;

    assign c_t[0] = c0;
    assign c_t[1] = {24'd0, c1};
    assign c_t[2] = {16'd0, c2};
    assign c_t[3] = {24'd0, c3};

    pipelined_add_sub #(.N(32), .STAGES(4)) u_dut_32x4 (
        .clk(clk), .rst(rst), .in_valid(in_valid_t[0]), .in_ready(in_ready_t[0]),
        .op(op_t[0]), .a(a_t[0]), .b(b_t[0]), .carry_in(cin_t[0]),
        .out_valid(out_valid_t[0]), .out_ready(out_ready_t[0]), .c(c0),
        .carry_out(co_t[0]), .overflow(ov_t[0]));

    pipelined_add_sub #(.N(8), .STAGES(2)) u_dut_8x2 (
        .clk(clk), .rst(rst), .in_valid(in_valid_t[1]), .in_ready(in_ready_t[1]),
        .op(op_t[1]), .a(a_t[1][7:0]), .b(b_t[1][7:0]), .carry_in(cin_t[1]),
        .out_valid(out_valid_t[1]), .out_ready(out_ready_t[1]), .c(c1),
        .carry_out(co_t[1]), .overflow(ov_t[1]));

    pipelined_add_sub #(.N(16), .STAGES(4)) u_dut_16x4 (
        .clk(clk), .rst(rst), .in_valid(in_valid_t[2]), .in_ready(in_ready_t[2]),
        .op(op_t[2]), .a(a_t[2][15:0]), .b(b_t[2][15:0]), .carry_in(cin_t[2]),
        .out_valid(out_valid_t[2]), .out_ready(out_ready_t[2]), .c(c2),
        .carry_out(co_t[2]), .overflow(ov_t[2]));

    pipelined_add_sub #(.N(8), .STAGES(1)) u_dut_8x1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_t[3]), .in_ready(in_ready_t[3]),
        .op(op_t[3]), .a(a_t[3][7:0]), .b(b_t[3][7:0]), .carry_in(cin_t[3]),
        .out_valid(out_valid_t[3]), .out_ready(out_ready_t[3]), .c(c3),
        .carry_out(co_t[3]), .overflow(ov_t[3]));

    // Reference: unsigned sum/difference for c and carry, signed range test for overflow.
    function automatic exp_t model(input int n, input logic [31:0] a, input logic [31:0] b,
                                   input logic op, input logic cin);
        longint unsigned mask;
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned ures;
        longint          sa;
        longint          sb;
        longint          sres;
        longint          lim;
        exp_t            e;
        mask = (64'd1 << n) - 64'd1;
        ua   = 64'(a) & mask;
        ub   = 64'(b) & mask;
        lim  = longint'(64'd1 << (n - 1));
        sa   = ((ua >> (n - 1)) != 64'd0) ? longint'(ua) - 2 * lim : longint'(ua);
        sb   = ((ub >> (n - 1)) != 64'd0) ? longint'(ub) - 2 * lim : longint'(ub);
        if (op) begin
            ures = (ua - ub) & mask;
            e.co = (ua >= ub);
            sres = sa - sb;
        end else begin
            ures = ua + ub + 64'(cin);
            e.co = ((ures >> n) != 64'd0);
            sres = sa + sb + longint'(cin);
        end
        e.c  = 32'(ures & mask);
        e.ov = OVF_ON && ((sres >= lim) || (sres < -lim));
        return e;
    endfunction

    task automatic chk(input string name, input int i, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d: got 0x%0h, expected 0x%0h", name, i, act, exp);
        end
    endtask

    task automatic set_vec(input int k, input logic [31:0] a, input logic [31:0] b,
                           input logic op, input logic cin);
        va[k] = a; vb[k] = b; vop[k] = op; vcin[k] = cin;
    endtask

    // One isolated transaction with literal expectations and a measured latency.
    task automatic single(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic op, input logic cin, input logic [31:0] ec,
                          input logic eco, input logic eov, input int elat);
        int lat;
        @(posedge clk); #1;
        out_ready_t[i] = 1'b1;
        a_t[i] = a; b_t[i] = b; op_t[i] = op; cin_t[i] = cin;
        in_valid_t[i] = 1'b1;
        @(posedge clk); #1;
        in_valid_t[i] = 1'b0;
        lat = 1;
        while (!out_valid_t[i] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", i, 64'(lat), 64'(elat));
        chk("literal_result", i, 64'({ov_t[i], co_t[i], c_t[i]}), 64'({eov, eco, ec}));
    endtask

    // Send va/vb[0..n-1] with full handshake while out_ready follows rdy_pat.
    task automatic stream(input int i, input int n, input logic [15:0] rdy_pat, input bit chk_rdy);
        int   idx;
        int   cyc;
        logic acc;
        idx = 0;
        cyc = 0;
        while (idx < n && cyc < 200) begin
            out_ready_t[i] = (cyc < 16) ? rdy_pat[cyc[3:0]] : 1'b1;
            in_valid_t[i]  = 1'b1;
            a_t[i] = va[idx]; b_t[i] = vb[idx]; op_t[i] = vop[idx]; cin_t[i] = vcin[idx];
            #1;
            if (chk_rdy) chk("in_ready_vs_out_ready", i, 64'(in_ready_t[i]), 64'(out_ready_t[i]));
            acc = in_ready_t[i];
            @(posedge clk); #1;
            if (acc) idx++;
            cyc++;
        end
        in_valid_t[i] = 1'b0;
        chk("stream_accepted", i, 64'(idx), 64'(n));
    endtask

    task automatic drain(input int i);
        int n;
        n = 0;
        out_ready_t[i] = 1'b1;
        while (sb_q[i].size() != 0 && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_empty", i, 64'(sb_q[i].size()), 64'd0);
    endtask

    // Scoreboard: compare any presented result, pop on transfer, push on acceptance.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                chk("reset_hold", i, 64'({in_ready_t[i], out_valid_t[i]}), 64'd0);
                sb_q[i].delete();
            end else begin
                if (out_valid_t[i]) begin
                    if (sb_q[i].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result inst%0d: got c=0x%0h, expected no result", i, c_t[i]);
                    end else begin
                        chk("result", i, 64'({ov_t[i], co_t[i], c_t[i]}), 64'(sb_q[i][0]));
                        if (out_ready_t[i]) begin
                            void'(sb_q[i].pop_front());
                            delivered[i]++;
                        end
                    end
                end
                if (in_valid_t[i] && in_ready_t[i]) begin
                    sb_q[i].push_back(model(nw[i], a_t[i], b_t[i], op_t[i], cin_t[i]));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int stale;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid_t[i] = 1'b0; out_ready_t[i] = 1'b1;
            op_t[i] = 1'b0; cin_t[i] = 1'b0; a_t[i] = 32'd0; b_t[i] = 32'd0;
        end
        #2 rst = 1'b1;
        #2;
        for (int i = 0; i < 4; i++)
            chk("reset_state", i, 64'({in_ready_t[i], out_valid_t[i], ov_t[i], co_t[i], c_t[i]}), 64'd0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) chk("ready_after_reset", i, 64'(in_ready_t[i]), 64'd1);

        // Pin the model with hand-computed values.
        chk("model_pin_wrap", 0, 64'(model(32, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0)), 64'({1'b0, 1'b1, 32'h0}));
        chk("model_pin_sub", 0, 64'(model(32, 32'd5, 32'd7, 1'b1, 1'b1)), 64'({1'b0, 1'b0, 32'hFFFF_FFFE}));
        chk("model_pin_8add", 3, 64'(model(8, 32'h80, 32'h80, 1'b0, 1'b0)), 64'({OVF_ON, 1'b1, 32'h0}));
        chk("model_pin_8sub", 1, 64'(model(8, 32'h80, 32'h01, 1'b1, 1'b0)), 64'({OVF_ON, 1'b1, 32'h7F}));

        // 32-bit, 4 stages: wrap, subtract ignoring carry_in, signed overflow.
        single(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 4);
        single(0, 32'd5, 32'd7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 4);
        single(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, OVF_ON, 4);

        // 32-bit stream under an irregular out_ready pattern.
        set_vec(0, 32'h0001_0000, 32'h0000_0001, 1'b1, 1'b0);
        set_vec(1, 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0);
        set_vec(2, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b1);
        set_vec(3, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0);
        set_vec(4, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 1'b1);
        set_vec(5, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        set_vec(6, 32'h00FF_00FF, 32'hFF00_FF00, 1'b0, 1'b1);
        set_vec(7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
        stream(0, 8, 16'h6CB5, 1'b0);
        drain(0);

        // 8-bit, 2 stages: six back-to-back, out_ready low in cycles 3..5.
        set_vec(0, 32'h12, 32'h34, 1'b0, 1'b0);
        set_vec(1, 32'hFF, 32'h01, 1'b0, 1'b0);
        set_vec(2, 32'h7F, 32'h01, 1'b0, 1'b0);
        set_vec(3, 32'h10, 32'h20, 1'b1, 1'b0);
        set_vec(4, 32'h80, 32'h01, 1'b1, 1'b0);
        set_vec(5, 32'h0F, 32'hF0, 1'b0, 1'b1);
        stream(1, 6, 16'hFFC7, 1'b1);
        drain(1);
        chk("delivered_count", 1, 64'(delivered[1]), 64'd6);

        // 8-bit, 1 stage: single registered add.
        single(3, 32'h80, 32'h80, 1'b0, 1'b0, 32'h00, 1'b1, OVF_ON, 1);

        // 16-bit, 4 stages: reset with three transactions in flight.
        set_vec(0, 32'h1111, 32'h2222, 1'b0, 1'b0);
        set_vec(1, 32'hFFFF, 32'h0001, 1'b0, 1'b0);
        set_vec(2, 32'h0100, 32'h0200, 1'b1, 1'b0);
        stream(2, 3, 16'h0000, 1'b0);
        n = 0;
        while (!out_valid_t[2] && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("first_at_output", 2, 64'(out_valid_t[2]), 64'd1);
        chk("inflight_before_reset", 2, 64'(sb_q[2].size()), 64'd3);
        rst = 1'b1;
        #1;
        chk("reset_clears_output", 2, 64'({out_valid_t[2], ov_t[2], co_t[2], c_t[2]}), 64'd0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready_t[2] = 1'b1;
        stale = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid_t[2]) stale++;
        end
        chk("no_stale_after_reset", 2, 64'(stale), 64'd0);
        single(2, 32'h1234, 32'h0FFF, 1'b1, 1'b0, 32'h0235, 1'b1, 1'b0, 4);

        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) chk("final_empty", i, 64'(sb_q[i].size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_add_sub.md
PIPELINED_ADD_SUB -- requirements
Module: pipelined_add_sub

Interface
REQ-001 SHALL have parameter N, default 32: data-path width in bits; legal range 2..128.
REQ-002 SHALL have parameter STAGES, default 4: pipeline depth; legal range 1..N with N % STAGES == 0; each stage handles a slice W = N/STAGES bits wide.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: the operand set on the inputs is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts an operand set this cycle.
REQ-007 SHALL have port op, input, 1 bit: 0 = add, 1 = subtract.
REQ-008 SHALL have ports a and b, input, N bits each: operands A and B.
REQ-009 SHALL have port carry_in, input, 1 bit: carry in; used only when op = 0.
REQ-010 SHALL have port out_valid, output, 1 bit: a result is presented.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-012 SHALL have port c, output, N bits: result sum or difference.
REQ-013 SHALL have port carry_out, output, 1 bit: carry out of bit N-1.
REQ-014 SHALL have port overflow, output, 1 bit: two's-complement signed overflow flag.

Function
REQ-015 SHALL compute {carry_out,c} = a + b + carry_in for op = 0, and a + ~b + 1 for op = 1, ignoring carry_in when op = 1.
REQ-016 SHALL compute slice k (bits k*W..k*W+W-1) in stage k; the carry from stage k SHALL be registered into stage k+1.
REQ-017 SHALL skew-delay the unprocessed operand slices and the op bit through the stages.
REQ-018 SHALL deskew the computed result slices so the full c emerges aligned.
REQ-019 SHALL present a result on out_valid exactly STAGES cycles after acceptance when out_ready is held high, giving a latency of STAGES.
REQ-020 SHALL accept a transaction when in_valid && in_ready, and transfer a result when out_valid && out_ready.
REQ-021 SHALL advance the whole pipeline only when adv = !out_valid || out_ready; in_ready SHALL equal adv, with no combinational path from in_valid to in_ready.
REQ-022 SHALL hold c, carry_out, overflow and out_valid stable while out_valid && !out_ready.
REQ-023 SHALL sustain a throughput of one transaction per cycle with no bubbles while out_ready stays high.
REQ-024 SHALL carry empty slots (bubbles) with valid = 0 through the stages; bubbles SHALL never assert out_valid.
REQ-025 SHALL deliver results in acceptance order, with no loss or duplication under any out_ready pattern.
REQ-026 SHALL, when STAGES = 1, produce a single registered full-width add/subtract with latency 1.
REQ-027 SHALL wrap modulo 2^N; c SHALL be the low N bits and the excess SHALL appear on carry_out.

Reset
REQ-028 SHALL clear every stage valid bit to 0 on rst assertion, immediately and regardless of clk.
REQ-029 SHALL clear c, carry_out, overflow and out_valid to 0 on rst.
REQ-030 SHALL hold in_ready at 0 while rst is high.
REQ-031 SHALL discard in-flight transactions on reset mid-operation; no result from before reset SHALL appear afterwards.
REQ-032 SHALL allow the first acceptance on the first rising clk edge after rst deasserts.

Configuration
REQ-033 SHALL, with macro PIPELINED_ADD_SUB_OVERFLOW_EN defined, drive overflow = carry into bit N-1 XOR carry_out, registered with the result.
REQ-034 SHALL, without PIPELINED_ADD_SUB_OVERFLOW_EN, tie overflow to constant 0 and instantiate no overflow logic.

Verification
REQ-035 SHALL cover, N=32, STAGES=4, out_ready=1: a=0xFFFFFFFF, b=0x00000001, carry_in=0, op=0 -> after 4 cycles c=0x00000000, carry_out=1, overflow=0.
REQ-036 SHALL cover, N=32, STAGES=4: a=5, b=7, op=1, carry_in=1 -> c=0xFFFFFFFE, carry_out=0, overflow=0.
REQ-037 SHALL cover, N=32: a=0x7FFFFFFF, b=1, op=0 -> c=0x80000000, carry_out=0; overflow=1 with the macro, 0 without.
REQ-038 SHALL cover, N=8, STAGES=2: 6 back-to-back transactions with out_ready low for cycles 3-5 -> in_ready low for the same cycles, all 6 results correct and in order, no drops.
REQ-039 SHALL cover, N=16, STAGES=4: rst pulsed while 3 transactions are in flight -> out_valid=0 immediately and no stale result after release.
REQ-040 SHALL cover, N=8, STAGES=1: a=0x80, b=0x80, op=0 -> c=0x00, carry_out=1, overflow=1 (macro on), 1 cycle latency.
